// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory fetch, instruction register and next-PC selection.
// Define FETCH_PERFCNT_EN to add the retired_cnt/stall_cnt performance counter outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic        fetch_err
`ifdef FETCH_PERFCNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;

    logic             req_raw;
    logic             valid_raw;
    logic [31:0]      pc_inc;
    logic [31:0]      branch_target;
    logic [31:0]      jump_target;
    logic [31:0]      next_pc;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        wait_cnt_d    = '0;
        fetch_err_d   = fetch_err_q;
        req_raw       = 1'b0;
        valid_raw     = 1'b0;
        pc_inc        = pc_q + 32'd4;
        branch_target = pc_inc + (signimm << 2);
        jump_target   = {pc_inc[31:28], instr_q[25:0], 2'b00};
        if (jump) begin
            next_pc = jump_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_inc;
        end

        case (state_q)
            S_REQ: begin
                if (!halt) begin
                    req_raw = 1'b1;
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            // halt is deliberately ignored here: once issued, a request is held until ack or timeout
            S_WAIT: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (TIMEOUT != 0 && wait_cnt_d == CNT_W'(TIMEOUT)) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                valid_raw = 1'b1;
                pc_d      = next_pc;
                state_d   = S_REQ;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Gating with reset drops a pending request in the reset cycle itself, so a late ack cannot be taken.
    assign imem_req    = req_raw && !reset;
    assign instr_valid = valid_raw && !reset;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pcplus4     = pc_inc;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign fetch_err   = fetch_err_q;

`ifdef FETCH_PERFCNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (state_q == S_EXEC) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
        if (state_q == S_WAIT || (state_q == S_REQ && halt)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the fetch/execute sequence.
module tb_fetch_unit;

    localparam int          TB_TIMEOUT  = 4;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] signimm = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_err;
`ifdef FETCH_PERFCNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .fetch_err   (fetch_err)
`ifdef FETCH_PERFCNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    // Behavioural model: an instruction is either being executed, being waited for, or about to be requested.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_exec;
    bit          m_fetch;
    bit          m_err;
    int          m_waits;
    logic [31:0] m_retired;
    logic [31:0] m_stall;

    function automatic logic [31:0] expectedNextPc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                                   input logic j, input logic b, input logic [31:0] imm);
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        if (j) return {seq[31:28], ins[25:0], 2'b00};
        if (b) return seq + imm * 32'd4;
        return seq;
    endfunction

    task automatic modelStep();
        if (reset) begin
            m_pc      = TB_RESET_PC;
            m_instr   = 32'h0;
            m_exec    = 1'b0;
            m_fetch   = 1'b0;
            m_err     = 1'b0;
            m_waits   = 0;
            m_retired = 32'h0;
            m_stall   = 32'h0;
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_exec) begin
            m_retired = m_retired + 32'd1;
            m_pc      = expectedNextPc(m_pc, m_instr, jump, pcsrc, signimm);
            m_exec    = 1'b0;
        end else if (!m_fetch) begin
            if (halt) begin
                m_stall = m_stall + 32'd1;
            end else if (imem_ack) begin
                m_instr = imem_rdata;
                m_exec  = 1'b1;
            end else begin
                m_fetch = 1'b1;
                m_waits = 0;
            end
        end else begin
            m_stall = m_stall + 32'd1;
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_exec  = 1'b1;
                m_fetch = 1'b0;
            end else begin
                m_waits++;
                if (TB_TIMEOUT != 0 && m_waits == TB_TIMEOUT) begin
                    m_err   = 1'b1;
                    m_fetch = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit a, input logic [31:0] rd,
                                 input bit ps, input bit j, input logic [31:0] si);
        reset      = r;
        halt       = h;
        imem_ack   = a;
        imem_rdata = rd;
        pcsrc      = ps;
        jump       = j;
        signimm    = si;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch from the request phase, ack after 'delay' wait cycles, then execute with the given controls.
    task automatic fetchOne(input logic [31:0] word, input int delay, input bit ps, input bit j,
                            input logic [31:0] si);
        applyStimulus(1'b0, 1'b0, delay == 0, word, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < delay; i++) begin
            stepCycle();
            imem_ack = (i == delay - 1);
        end
        stepCycle();
        imem_ack = 1'b0;
        pcsrc    = ps;
        jump     = j;
        signimm  = si;
        #1;
        checkOutput("exec_valid", {31'h0, instr_valid}, 32'h1);
        checkOutput("exec_instr", instr, word);
        stepCycle();
        pcsrc = 1'b0;
        jump  = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            if (reset) check_en = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("imem_req", {31'h0, imem_req},
                            {31'h0, !reset && !m_err && !m_exec && (m_fetch || !halt)});
                checkOutput("instr_valid", {31'h0, instr_valid}, {31'h0, !reset && m_exec});
                checkOutput("imem_addr", imem_addr, m_pc);
                checkOutput("pc", pc, m_pc);
                checkOutput("pcplus4", pcplus4, m_pc + 32'd4);
                checkOutput("instr", instr, m_instr);
                checkOutput("op", {26'h0, op}, {26'h0, m_instr[31:26]});
                checkOutput("funct", {26'h0, funct}, {26'h0, m_instr[5:0]});
                checkOutput("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
`ifdef FETCH_PERFCNT_EN
                checkOutput("retired_cnt", retired_cnt, m_retired);
                checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
            end
        end
    end

    initial begin
        bit r;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_err", {31'h0, fetch_err}, 32'h0);

        // Ack held high: two cycles per instruction, sequential addresses.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t1_addr0", imem_addr, 32'h0);
        checkOutput("t1_req0", {31'h0, imem_req}, 32'h1);
        checkOutput("t1_valid0", {31'h0, instr_valid}, 32'h0);
        stepCycle();
        checkOutput("t1_valid1", {31'h0, instr_valid}, 32'h1);
        checkOutput("t1_req1", {31'h0, imem_req}, 32'h0);
        stepCycle();
        checkOutput("t1_addr4", imem_addr, 32'h4);
        checkOutput("t1_valid2", {31'h0, instr_valid}, 32'h0);
        stepCycle();
        checkOutput("t1_valid3", {31'h0, instr_valid}, 32'h1);
        stepCycle();
        checkOutput("t1_addr8", imem_addr, 32'h8);

        // Next-PC selection, including jump-over-branch priority and 32-bit wrap.
        fetchOne(32'h0800_0040, 0, 1'b0, 1'b1, 32'h0);
        checkOutput("t2_jump_to_100", imem_addr, 32'h0000_0100);
        fetchOne(32'h0, 1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        checkOutput("t2_branch_back", imem_addr, 32'h0000_00FC);
        fetchOne(32'h0, 0, 1'b1, 1'b0, 32'h0FFF_FFC4);
        checkOutput("t3_branch_fwd", imem_addr, 32'h4000_0010);
        fetchOne(32'h0800_0040, 2, 1'b1, 1'b1, 32'h0000_1234);
        checkOutput("t3_jump_wins", imem_addr, 32'h4000_0100);
        fetchOne(32'h0, 0, 1'b1, 1'b0, 32'h2FFF_FFBE);
        checkOutput("wrap_pc", imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_pcplus4", pcplus4, 32'h0);
        fetchOne(32'h0, 0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_next", imem_addr, 32'h0);

        // Ack after three wait cycles with halt pulsed mid-wait.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            halt     = (i == 1);
            imem_ack = (i == 3);
            #1;
            checkOutput("t5_addr", imem_addr, 32'h0);
            checkOutput("t5_req", {31'h0, imem_req}, 32'h1);
            checkOutput("t5_valid", {31'h0, instr_valid}, 32'h0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t5_valid_pulse", {31'h0, instr_valid}, 32'h1);
        checkOutput("t5_instr", instr, 32'hDEAD_BEEF);
        checkOutput("t5_op", {26'h0, op}, 32'h37);
        checkOutput("t5_funct", {26'h0, funct}, 32'h2F);
        stepCycle();
        checkOutput("t5_valid_end", {31'h0, instr_valid}, 32'h0);
        checkOutput("t5_addr_next", imem_addr, 32'h4);

        // Timeout: no ack ever arrives.
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("t4_wait_req", {31'h0, imem_req}, 32'h1);
            checkOutput("t4_wait_err", {31'h0, fetch_err}, 32'h0);
        end
        stepCycle();
        checkOutput("t4_err", {31'h0, fetch_err}, 32'h1);
        checkOutput("t4_req_dropped", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        stepCycle();
        checkOutput("t4_err_sticky", {31'h0, fetch_err}, 32'h1);
        checkOutput("t4_err_req", {31'h0, imem_req}, 32'h0);
        checkOutput("t4_err_pc", pc, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t4_rst_err", {31'h0, fetch_err}, 32'h0);
        checkOutput("t4_rst_addr", imem_addr, TB_RESET_PC);
        checkOutput("t4_rst_req", {31'h0, imem_req}, 32'h1);

`ifdef FETCH_PERFCNT_EN
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepCycle();
        for (int i = 0; i < 10; i++) begin
            fetchOne(32'h0000_0020 + i, 2, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("t6_retired", retired_cnt, 32'd10);
        checkOutput("t6_stall", stall_cnt, 32'd20);
`endif

        // Randomized traffic; reset is made likely once the model has reached the error state.
        for (int c = 0; c < 3000; c++) begin
            r = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            applyStimulus(r, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 5, $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom);
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
